// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state, field and opcode definitions for the ALU instruction sequencer
package alu_pkg;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} seq_state_t;

  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int DST_BIT  = 4;
  localparam int SRCA_BIT = 3;
  localparam int SRCB_BIT = 2;

  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

  // Wait counters cover READ_LAT up to 7 and ALU_LAT up to 15.
  localparam int RD_CNT_W = 3;
  localparam int EX_CNT_W = 4;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// rtl/alu_instr_sequencer_if.sv - instruction handshake and bank/ALU control bundle
interface alu_instr_sequencer_if #(
  parameter int INSTR_W = 8
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic [INSTR_W-1:0] bank_instr;
  logic               bank_wr;
  logic [2:0]         alu_op;
  logic               alu_go;
  logic               busy;

  modport master (
    output in_valid, in_instr,
    input  in_ready, bank_instr, bank_wr, alu_op, alu_go, busy
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, bank_instr, bank_wr, alu_op, alu_go, busy
  );
endinterface

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down-counter with zero flag
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  // Saturates at zero so a stray decrement can never wrap within a state.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - multi-cycle bank/ALU instruction sequencer; SEQ_PERF_CNT_EN adds retired_cnt
module alu_instr_sequencer
  import alu_pkg::*;
#(
  parameter int INSTR_W  = 8,
  parameter int READ_LAT = 2,
  parameter int ALU_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_instr_sequencer_if.slave seq
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     retired_cnt
`endif
);
  seq_state_t state, next_state;
  logic xfer, latch_instr, go_next;
  logic rd_load, rd_dec, rd_zero;
  logic ex_load, ex_dec, ex_zero;
  logic [INSTR_W-1:0] bank_instr_q;
  logic alu_go_q;

  assign seq.in_ready   = (state == IDLE) || (state == WB);
  assign seq.busy       = (state != IDLE);
  assign seq.bank_wr    = (state == WB);
  assign seq.alu_go     = alu_go_q;
  assign seq.bank_instr = bank_instr_q;
  assign seq.alu_op     = bank_instr_q[OPC_MSB:OPC_LSB];
  assign xfer           = seq.in_valid && seq.in_ready;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    latch_instr = 1'b0;
    rd_load     = 1'b0;
    rd_dec      = 1'b0;
    ex_load     = 1'b0;
    ex_dec      = 1'b0;
    go_next     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          latch_instr = 1'b1;
          rd_load     = 1'b1;
          next_state  = READ;
        end
      end
      READ: begin
        rd_dec = 1'b1;
        if (rd_zero) begin
          ex_load    = 1'b1;
          go_next    = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        ex_dec = 1'b1;
        if (ex_zero)
          next_state = WB;
      end
      WB: begin
        // Back-to-back issue: the new instruction replaces bank_instr only on the edge leaving WB.
        if (xfer) begin
          latch_instr = 1'b1;
          rd_load     = 1'b1;
          next_state  = READ;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_instr_q <= '0;
      alu_go_q     <= 1'b0;
    end else begin
      if (latch_instr)
        bank_instr_q <= seq.in_instr;
      alu_go_q <= go_next;
    end
  end

  seq_down_counter #(.W(RD_CNT_W)) u_rd_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_load),
    .load_val (RD_CNT_W'(READ_LAT - 1)),
    .dec      (rd_dec),
    .zero     (rd_zero)
  );

  seq_down_counter #(.W(EX_CNT_W)) u_ex_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ex_load),
    .load_val (EX_CNT_W'(ALU_LAT - 1)),
    .dec      (ex_dec),
    .zero     (ex_zero)
  );

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      retired_cnt <= '0;
    else if (state == WB)
      retired_cnt <= retired_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - directed self-checking bench for alu_instr_sequencer
module tb_alu_instr_sequencer;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_instr_sequencer_if #(.INSTR_W(8)) if0 ();
  alu_instr_sequencer_if #(.INSTR_W(8)) if1 ();

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retired0;
  logic [1:0]  retired1;
`endif

  alu_instr_sequencer #(.INSTR_W(8), .READ_LAT(2), .ALU_LAT(1), .CNT_W(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .seq   (if0.slave)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired_cnt (retired0)
`endif
  );

  alu_instr_sequencer #(.INSTR_W(8), .READ_LAT(2), .ALU_LAT(4), .CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .seq   (if1.slave)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired_cnt (retired1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mk(input logic [2:0] op, input logic d, input logic a, input logic b);
    logic [7:0] r;
    r = '0;
    r[OPC_MSB:OPC_LSB] = op;
    r[DST_BIT]  = d;
    r[SRCA_BIT] = a;
    r[SRCB_BIT] = b;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if0.busy); end
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", if0.in_ready); end
    checks++; if (if0.bank_instr !== 8'h00) begin errors++; $display("FAIL reset_bank_instr got %h want 00", if0.bank_instr); end
    checks++; if (if0.bank_wr !== 1'b0) begin errors++; $display("FAIL reset_bank_wr got %b want 0", if0.bank_wr); end
    checks++; if (if0.alu_go !== 1'b0) begin errors++; $display("FAIL reset_alu_go got %b want 0", if0.alu_go); end
    checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", if1.busy); end
`ifdef SEQ_PERF_CNT_EN
    checks++; if (retired0 !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired0); end
`endif
  endtask

  task automatic test_single();
    if0.in_valid = 1'b1;
    if0.in_instr = mk(OP_0, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if0.in_valid = 1'b0;
      checks++; if (if0.in_ready !== !(c >= 1 && c <= 3)) begin errors++; $display("FAIL single_in_ready c%0d got %b", c, if0.in_ready); end
      checks++; if (if0.alu_go !== (c == 3)) begin errors++; $display("FAIL single_alu_go c%0d got %b", c, if0.alu_go); end
      checks++; if (if0.bank_wr !== (c == 4)) begin errors++; $display("FAIL single_bank_wr c%0d got %b", c, if0.bank_wr); end
      checks++; if (if0.busy !== (c <= 4)) begin errors++; $display("FAIL single_busy c%0d got %b", c, if0.busy); end
      checks++; if (if0.bank_instr !== 8'h18) begin errors++; $display("FAIL single_bank_instr c%0d got %h want 18", c, if0.bank_instr); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_instr;
    if0.in_valid = 1'b1;
    if0.in_instr = 8'h18;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) if0.in_instr = mk(OP_4, 1'b0, 1'b0, 1'b1);
      if (c == 5) if0.in_valid = 1'b0;
      exp_instr = (c <= 4) ? 8'h18 : 8'h84;
      checks++; if (if0.bank_wr !== (c == 4 || c == 8)) begin errors++; $display("FAIL b2b_bank_wr c%0d got %b", c, if0.bank_wr); end
      checks++; if (if0.busy !== (c <= 8)) begin errors++; $display("FAIL b2b_busy c%0d got %b", c, if0.busy); end
      checks++; if (if0.in_ready !== (c == 4 || c >= 8)) begin errors++; $display("FAIL b2b_in_ready c%0d got %b", c, if0.in_ready); end
      checks++; if (if0.bank_instr !== exp_instr) begin errors++; $display("FAIL b2b_bank_instr c%0d got %h want %h", c, if0.bank_instr, exp_instr); end
      checks++; if (if0.alu_op !== exp_instr[7:5]) begin errors++; $display("FAIL b2b_alu_op c%0d got %0d want %0d", c, if0.alu_op, exp_instr[7:5]); end
    end
  endtask

  task automatic test_alu_lat4();
    if1.in_valid = 1'b1;
    if1.in_instr = mk(OP_7, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if1.in_valid = 1'b0;
      checks++; if (if1.alu_go !== (c == 3)) begin errors++; $display("FAIL lat4_alu_go c%0d got %b", c, if1.alu_go); end
      checks++; if (if1.bank_wr !== (c == 7)) begin errors++; $display("FAIL lat4_bank_wr c%0d got %b", c, if1.bank_wr); end
      checks++; if (if1.busy !== (c <= 7)) begin errors++; $display("FAIL lat4_busy c%0d got %b", c, if1.busy); end
      checks++; if (if1.alu_op !== 3'd7) begin errors++; $display("FAIL lat4_alu_op c%0d got %0d want 7", c, if1.alu_op); end
    end
  endtask

  task automatic test_reset_mid();
    if1.in_valid = 1'b1;
    if1.in_instr = 8'hE8;
    for (int c = 1; c <= 4; c++) begin
      step();
      if1.in_valid = 1'b0;
      checks++; if (if1.bank_wr !== 1'b0) begin errors++; $display("FAIL midrst_pre_bank_wr c%0d got %b", c, if1.bank_wr); end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", if1.busy); end
    checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", if1.in_ready); end
    checks++; if (if1.alu_go !== 1'b0) begin errors++; $display("FAIL midrst_alu_go got %b want 0", if1.alu_go); end
    checks++; if (if1.bank_instr !== 8'h00) begin errors++; $display("FAIL midrst_bank_instr got %h want 00", if1.bank_instr); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (if1.bank_wr !== 1'b0) begin errors++; $display("FAIL midrst_post_bank_wr c%0d got %b want 0", c, if1.bank_wr); end
      step();
    end
  endtask

  task automatic test_idle_hold();
    if0.in_valid = 1'b1;
    if0.in_instr = mk(OP_2, 1'b0, 1'b0, 1'b1);
    step();
    if0.in_valid = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    if0.in_instr = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      if0.in_valid = c[0];
      if0.in_valid = 1'b0;
      step();
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL idle_busy c%0d got %b want 0", c, if0.busy); end
      checks++; if (if0.bank_instr !== 8'h44) begin errors++; $display("FAIL idle_bank_instr c%0d got %h want 44", c, if0.bank_instr); end
      checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready c%0d got %b want 1", c, if0.in_ready); end
    end
  endtask

  task automatic test_reset_and_valid();
    reset = 1'b1;
    if0.in_valid = 1'b1;
    if0.in_instr = 8'h33;
    step();
    reset = 1'b0;
    if0.in_valid = 1'b0;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL rstvalid_busy got %b want 0", if0.busy); end
    checks++; if (if0.bank_instr !== 8'h00) begin errors++; $display("FAIL rstvalid_bank_instr got %h want 00", if0.bank_instr); end
    step();
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL rstvalid_busy2 got %b want 0", if0.busy); end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1;
      if1.in_valid = 1'b1;
      if0.in_instr = 8'h18;
      if1.in_instr = 8'h84;
      step();
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      for (int c = 0; c < 8; c++) step();
    end
    checks++; if (retired0 !== 16'd5) begin errors++; $display("FAIL perf_cnt16 got %0d want 5", retired0); end
    checks++; if (retired1 !== 2'd1) begin errors++; $display("FAIL perf_cnt2 got %0d want 1", retired1); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (retired0 !== 16'd0) begin errors++; $display("FAIL perf_cnt_clear got %0d want 0", retired0); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    if0.in_valid = 1'b0;
    if0.in_instr = 8'h00;
    if1.in_valid = 1'b0;
    if1.in_instr = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_alu_lat4();
    test_reset_mid();
    test_idle_hold();
    test_reset_and_valid();
`ifdef SEQ_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Multi-cycle controller that sequences the 2-entry x 4-bit register bank and the ALU for one 8-bit instruction at a time.
- Accepts instructions over a valid/ready handshake and holds each one stable on the bank instruction bus.
- Waits out the bank read latency, then launches and times the ALU operation, then issues a single-cycle bank write-enable.
- Sits between the instruction source (test program or serial loader) and the bank/ALU datapath.

Parameters:
- INSTR_W, 8, instruction width; fields: opcode [7:5], dest [4], srcA [3], srcB [2], [1:0] unused.
- READ_LAT, 2, cycles from bank instruction presentation to valid data_A/data_B; legal range 1..7.
- ALU_LAT, 1, cycles the ALU needs after alu_go before its result is valid; legal range 1..15.
- CNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, instruction offered.
- in_instr, input, INSTR_W, offered instruction.
- in_ready, output, 1, sequencer can accept; a transfer occurs when in_valid and in_ready are both high on a rising edge.
- bank_instr, output, INSTR_W, instruction driven to the register bank decoder.
- bank_wr, output, 1, bank write-enable for the ALU result.
- alu_op, output, 3, opcode to the ALU; equals bank_instr[7:5].
- alu_go, output, 1, one-cycle ALU start pulse.
- busy, output, 1, high in any state other than IDLE.
- retired_cnt, output, CNT_W, completed-writeback count; present only with SEQ_PERF_CNT_EN.

Behaviour:
- Reset and clock: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, bank_instr=0, bank_wr=0, alu_go=0, busy=0, in_ready=1, retired_cnt=0.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On transfer, latch in_instr into bank_instr and go to READ with rd_cnt=READ_LAT-1.
- READ:
  - Hold bank_instr.
  - Decrement rd_cnt; when rd_cnt==0, go to EXEC with ex_cnt=ALU_LAT-1 and alu_go=1 for that first EXEC cycle only.
- EXEC:
  - alu_go is high only in the first EXEC cycle.
  - Decrement ex_cnt; when ex_cnt==0, go to WB.
- WB:
  - bank_wr=1 for exactly this one cycle; in_ready=1.
  - If a transfer occurs in WB, latch the new instruction and go directly to READ (back-to-back issue).
  - Otherwise go to IDLE.
  - bank_instr changes only on the edge that ends WB, so the bank's latched dest field stays valid for the write.
- Latency:
  - Accept edge = cycle 0; bank_wr is high in cycle READ_LAT+ALU_LAT+1.
  - Maximum issue rate: one instruction per READ_LAT+ALU_LAT+1 cycles.
- in_ready is low in READ and EXEC. in_instr is ignored when no transfer occurs.
- All 8 opcodes follow the same flow. Opcode 3'h6 has no sources; the sequencer still waits READ_LAT for uniform timing.
- Reset asserted mid-operation: next edge forces IDLE, bank_wr=0, alu_go=0. The in-flight instruction is dropped and no write occurs.
- reset and in_valid high together: reset wins and no transfer is recorded.
- Counters are sized ceil(log2(max+1)); no wrap occurs inside one state.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined: retired_cnt increments by 1 on every WB cycle, wraps modulo 2^CNT_W, and clears on reset.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - State enum (IDLE, READ, EXEC, WB).
  - Opcode field positions OPC_MSB=7, OPC_LSB=5, DST_BIT=4, SRCA_BIT=3, SRCB_BIT=2.
  - Opcode constants OP_0..OP_7.
- One natural sub-module, seq_down_counter: loadable down-counter with zero flag, instantiated twice (read wait and ALU wait).

Test Plan:
- Reset, then offer in_instr=8'h18 (op0, dest1, srcA1) at cycle 0 with READ_LAT=2, ALU_LAT=1 -> in_ready low in cycles 1-3; alu_go high in cycle 3; bank_wr high in cycle 4 only; bank_instr=8'h18 in cycles 1-4.
- in_valid held high with 8'h18 then 8'h84 -> second transfer on the WB edge; next bank_wr exactly 4 cycles after the first; no IDLE cycle between them.
- ALU_LAT=4, instr 8'hE8 -> alu_go a single pulse in cycle 3; bank_wr in cycle 7; busy high in cycles 1-7.
- Assert reset during EXEC -> next cycle busy=0, bank_wr never asserted for that instruction, in_ready=1.
- in_valid toggled low in IDLE -> no state change; bank_instr keeps its last value; busy=0.
- With SEQ_PERF_CNT_EN, issue 5 instructions -> retired_cnt=5; after reset -> 0. With CNT_W=2, 5 instructions -> retired_cnt=1.
